// File: rtl/pulse_gen_v2_pkg.sv
// ---------------------------------------------------------------------------
// package_settings_v_2
// Shared settings for the v2 pulse generator and its companion shaping
// filter: default sample width, rise/decay shifts, auto-trigger counter
// width and the pulse generator state encoding.
// ---------------------------------------------------------------------------
package package_settings_v_2;

    // Sample width shared with the trapezoidal shaping filter.
    localparam int SIZE_FILTER_DATA = 16;

    // Rise length is 2^RISE_SHIFT samples.
    localparam int RISE_SHIFT_v_2   = 2;

    // Decay constant M = 2^DECAY_SHIFT; must match the shaper's M.
    localparam int DECAY_SHIFT_v_2  = 5;

    // Width of the auto-trigger interval counter.
    localparam int PERIOD_W_v_2     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_DECAY = 2'd2
    } pulse_state_t;

endpackage

// File: rtl/pulse_gen_v2_period_timer.sv
// ---------------------------------------------------------------------------
// pulse_period_timer
// Free-running interval counter that produces a one-cycle tick every
// 'period' cycles while enabled.
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-low
//   en     in   counting enable; counter held at 0 while low
//   period in   interval in cycles; 0 disables ticking
//   tick   out  combinational, high on the cycle whose edge ends an interval
// ---------------------------------------------------------------------------
module pulse_period_timer #(
    parameter int PERIOD_W = package_settings_v_2::PERIOD_W_v_2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] r_count;
    logic                w_active;

    // The count restarts on every tick whether or not the tick is used
    // downstream, so the interval stays fixed even when a tick is dropped.
    assign w_active = en && (period != '0);
    assign tick     = w_active && (r_count == (period - PERIOD_W'(1)));

    // Shrinking 'period' below the current count lets the counter run on
    // until it wraps; that single long interval is accepted behaviour.
    always_ff @(posedge clk) begin
        if (!reset || !w_active) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pulse_gen_v2.sv
// ---------------------------------------------------------------------------
// pulse_gen_v2
// Generates exponential-tail detector pulses (linear rise over 2^RISE_SHIFT
// samples, then decay by 1/M per sample) as stimulus for a trapezoidal
// shaping filter with the same M.
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-low
//   trig        in   external pulse request, level-sampled
//   amp         in   unsigned pulse amplitude, captured at acceptance
//   baseline    in   signed offset added to every output sample
//   auto_en     in   enables the periodic internal trigger
//   period      in   auto-trigger interval in cycles, 0 = off
//   trig_ack    out  one-cycle pulse per accepted trigger
//   busy        out  high while a pulse is rising or decaying
//   output_data out  registered signed sample stream
// ---------------------------------------------------------------------------
module pulse_gen_v2 #(
    parameter int SIZE_FILTER_DATA = package_settings_v_2::SIZE_FILTER_DATA,
    parameter int RISE_SHIFT       = package_settings_v_2::RISE_SHIFT_v_2,
    parameter int DECAY_SHIFT      = package_settings_v_2::DECAY_SHIFT_v_2,
    parameter int PERIOD_W         = package_settings_v_2::PERIOD_W_v_2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               trig,
    input  logic        [SIZE_FILTER_DATA-1:0] amp,
    input  logic signed [SIZE_FILTER_DATA-1:0] baseline,
    input  logic                               auto_en,
    input  logic        [PERIOD_W-1:0]         period,
    output logic                               trig_ack,
    output logic                               busy,
    output logic signed [SIZE_FILTER_DATA-1:0] output_data
);
    import package_settings_v_2::*;

    localparam int W        = SIZE_FILTER_DATA;
    localparam int ACC_W    = W + 2;
    localparam int SUM_W    = ACC_W + 1;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int CNT_W    = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;

    localparam logic        [CNT_W-1:0] LAST_CNT    = CNT_W'(RISE_LEN - 2);
    localparam logic        [W-1:0]     LOW_MASK    = W'((1 << RISE_SHIFT) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX     = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] DECAY_LIMIT = ACC_W'(2 ** DECAY_SHIFT);
    localparam logic signed [ACC_W-1:0] NEG_LIMIT   = -DECAY_LIMIT;
    localparam logic signed [SUM_W-1:0] OUT_MAX     = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN     = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};

    pulse_state_t              r_state, w_state_next;
    logic signed [ACC_W-1:0]   r_acc, w_acc_next;
    logic        [CNT_W-1:0]   r_rise_cnt, w_cnt_next;
    logic        [W-1:0]       r_amp, w_amp_next;
    logic                      r_trig_ack;
    logic signed [W-1:0]       r_output_data, w_out_sat;
    logic                      w_tick;
    logic                      w_accept;
    logic                      w_do_add;
    logic        [W-1:0]       w_inc;
    logic        [W-1:0]       w_last_inc;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_out_sum;

    pulse_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_period_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (auto_en),
        .period (period),
        .tick   (w_tick)
    );

    // A request (external or auto) is only honoured outside RISE, so a
    // held trig or a tick during the rise is simply lost.
    assign w_accept = (trig || w_tick) && (r_state != ST_RISE);

    // The final rise increment must make the total exactly amp:
    // amp - (RISE_LEN-1)*step == step + (amp mod RISE_LEN).
    assign w_last_inc = (r_amp >> RISE_SHIFT) + (r_amp & LOW_MASK);

    // Next-state logic: acceptance (including pile-up from DECAY) wins,
    // otherwise RISE keeps adding and DECAY shrinks acc toward zero.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_rise_cnt;
        w_amp_next   = r_amp;
        w_inc        = '0;
        w_do_add     = 1'b0;
        w_sum        = '0;

        if (w_accept) begin
            w_amp_next = amp;
            w_cnt_next = '0;
            w_do_add   = 1'b1;
            if (RISE_LEN == 1) begin
                w_inc        = amp;
                w_state_next = ST_DECAY;
            end else begin
                w_inc        = amp >> RISE_SHIFT;
                w_state_next = ST_RISE;
            end
        end else begin
            case (r_state)
                ST_RISE: begin
                    w_do_add = 1'b1;
                    if (r_rise_cnt == LAST_CNT) begin
                        w_inc        = w_last_inc;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_inc      = r_amp >> RISE_SHIFT;
                        w_cnt_next = r_rise_cnt + CNT_W'(1);
                    end
                end
                ST_DECAY: begin
                    // Below M the shift term is zero and acc would stall.
                    if ((r_acc < DECAY_LIMIT) && (r_acc > NEG_LIMIT)) begin
                        w_acc_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_acc_next = r_acc - (r_acc >>> DECAY_SHIFT);
                    end
                end
                default: begin
                end
            endcase
        end

        // Increments are never negative, so only the positive rail needs
        // clamping.
        if (w_do_add) begin
            w_sum = $signed({r_acc[ACC_W-1], r_acc})
                  + $signed({{(SUM_W-W){1'b0}}, w_inc});
            if (w_sum > SUM_MAX) begin
                w_acc_next = ACC_MAX;
            end else begin
                w_acc_next = w_sum[ACC_W-1:0];
            end
        end
    end

    // Output sample: baseline plus the accumulator value held before this
    // edge, clamped into the signed sample range.
    always_comb begin
        w_out_sum = $signed({{(SUM_W-W){baseline[W-1]}}, baseline})
                  + $signed({r_acc[ACC_W-1], r_acc});
        if (w_out_sum > OUT_MAX) begin
            w_out_sat = OUT_MAX[W-1:0];
        end else if (w_out_sum < OUT_MIN) begin
            w_out_sat = OUT_MIN[W-1:0];
        end else begin
            w_out_sat = w_out_sum[W-1:0];
        end
    end

    // State register; reset overrides any trigger arriving on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_rise_cnt    <= '0;
            r_amp         <= '0;
            r_trig_ack    <= 1'b0;
            r_output_data <= '0;
        end else begin
            r_state       <= w_state_next;
            r_acc         <= w_acc_next;
            r_rise_cnt    <= w_cnt_next;
            r_amp         <= w_amp_next;
            r_trig_ack    <= w_accept;
            r_output_data <= w_out_sat;
        end
    end

    assign trig_ack    = r_trig_ack;
    assign busy        = (r_state != ST_IDLE);
    assign output_data = r_output_data;

endmodule

// File: tb/tb_pulse_gen_v2.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_v2
// Scoreboard bench for pulse_gen_v2: stimulus schedules expected values
// tagged with the edge count at which they must be visible, and a monitor
// compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_pulse_gen_v2;

    localparam int SIG_OUT  = 0;
    localparam int SIG_ACK  = 1;
    localparam int SIG_BUSY = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               trig;
    logic        [15:0] amp;
    logic signed [15:0] baseline;
    logic               autoEn;
    logic        [15:0] period;
    logic               trigAck;
    logic               busy;
    logic signed [15:0] outputData;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   edgeCnt     = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    pulse_gen_v2 dut (
        .clk         (clk),
        .reset       (reset),
        .trig        (trig),
        .amp         (amp),
        .baseline    (baseline),
        .auto_en     (autoEn),
        .period      (period),
        .trig_ack    (trigAck),
        .busy        (busy),
        .output_data (outputData)
    );

    // 10-time-unit clock period.
    always #5 clk = ~clk;

    // Count rising edges so expectations can be pinned to "after edge n".
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Monitor: on each falling edge, retire every expectation that is due.
    exp_t               mon;
    logic signed [31:0] act;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= edgeCnt) begin
            mon = sbq.pop_front();
            case (mon.sig)
                SIG_OUT: act = outputData;
                SIG_ACK: act = {31'b0, trigAck};
                default: act = {31'b0, busy};
            endcase
            vectors++;
            if (mon.cyc != edgeCnt || act !== mon.val) begin
                miscompares++;
                $display("[TB] FAIL %s at edge %0d (seen %0d): got %0d, expected %0d",
                         mon.name, mon.cyc, edgeCnt, act, mon.val);
            end
        end
    end

    // Schedule one expectation; pushes must be in non-decreasing edge order.
    task automatic checkOutput(input int cyc, input int sig, input int val,
                               input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Drive reset/trig for the next rising edge, then move to the falling edge.
    task automatic applyStimulus(input logic rst, input logic tr);
        reset = rst;
        trig  = tr;
        @(negedge clk);
    endtask

    // Let time pass until every scheduled expectation has been retired.
    task automatic waitDrain();
        int budget = 3000;
        trig = 1'b0;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Directed scenarios.
    initial begin
        int t;
        int a;
        reset    = 1'b0;
        trig     = 1'b0;
        amp      = '0;
        baseline = '0;
        autoEn   = 1'b0;
        period   = 16'd100;
        repeat (2) @(negedge clk);

        // Reset state, then the idle output after release.
        t = edgeCnt + 1;
        checkOutput(t, SIG_OUT,  0, "reset_out");
        checkOutput(t, SIG_ACK,  0, "reset_ack");
        checkOutput(t, SIG_BUSY, 0, "reset_busy");
        applyStimulus(1'b0, 1'b0);
        t = edgeCnt + 1;
        checkOutput(t, SIG_OUT,  0, "idle_out");
        checkOutput(t, SIG_BUSY, 0, "idle_busy");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // Basic pulse with trig held 3 cycles, then pile-up at acc=939.
        baseline = 16'sd0;
        amp      = 16'd1000;
        t = edgeCnt + 1;
        checkOutput(t,    SIG_ACK,  1,    "ack_first");
        checkOutput(t,    SIG_BUSY, 1,    "busy_first");
        checkOutput(t+1,  SIG_OUT,  250,  "rise1");
        checkOutput(t+1,  SIG_ACK,  0,    "held_ack1");
        checkOutput(t+2,  SIG_OUT,  500,  "rise2");
        checkOutput(t+2,  SIG_ACK,  0,    "held_ack2");
        checkOutput(t+3,  SIG_OUT,  750,  "rise3");
        checkOutput(t+3,  SIG_ACK,  0,    "held_ack3");
        checkOutput(t+4,  SIG_OUT,  1000, "peak");
        checkOutput(t+5,  SIG_OUT,  969,  "decay1");
        checkOutput(t+6,  SIG_OUT,  939,  "decay2");
        checkOutput(t+6,  SIG_ACK,  1,    "pileup_ack");
        checkOutput(t+7,  SIG_OUT,  1189, "pile_rise1");
        checkOutput(t+7,  SIG_ACK,  0,    "pileup_ack_end");
        checkOutput(t+8,  SIG_OUT,  1439, "pile_rise2");
        checkOutput(t+9,  SIG_OUT,  1689, "pile_rise3");
        checkOutput(t+10, SIG_OUT,  1939, "pile_peak");
        a = 1939;
        for (int e = t + 10; e < t + 2000; e++) begin
            if (a < 32) begin
                checkOutput(e,   SIG_BUSY, 0, "tail_busy_end");
                checkOutput(e+1, SIG_OUT,  0, "tail_out_end");
                break;
            end
            a = a - (a >>> 5);
            checkOutput(e,   SIG_BUSY, 1, "tail_busy");
            checkOutput(e+1, SIG_OUT,  a, "tail_out");
        end
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitDrain();

        // Positive clamp with a large amplitude, cleared by reset.
        baseline = 16'sd1000;
        amp      = 16'd32767;
        t = edgeCnt + 1;
        checkOutput(t,   SIG_ACK,  1,     "big_ack");
        checkOutput(t+1, SIG_OUT,  9191,  "big_rise1");
        checkOutput(t+2, SIG_OUT,  17382, "big_rise2");
        checkOutput(t+3, SIG_OUT,  25573, "big_rise3");
        checkOutput(t+4, SIG_OUT,  32767, "big_clamp");
        checkOutput(t+5, SIG_OUT,  32744, "big_decay1");
        checkOutput(t+6, SIG_OUT,  0,     "big_reset_out");
        checkOutput(t+6, SIG_BUSY, 0,     "big_reset_busy");
        checkOutput(t+7, SIG_OUT,  0,     "big_reset_out2");
        checkOutput(t+8, SIG_OUT,  1000,  "baseline_only");
        checkOutput(t+8, SIG_BUSY, 0,     "baseline_busy");
        applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDrain();

        // Negative clamp: most negative baseline with a zero-amplitude pulse.
        baseline = -16'sd32768;
        amp      = 16'd0;
        t = edgeCnt + 1;
        checkOutput(t,   SIG_ACK,  1,      "neg_ack");
        checkOutput(t,   SIG_BUSY, 1,      "neg_busy");
        checkOutput(t+1, SIG_OUT,  -32768, "neg_out1");
        checkOutput(t+2, SIG_OUT,  -32768, "neg_out2");
        checkOutput(t+3, SIG_OUT,  -32768, "neg_out3");
        checkOutput(t+3, SIG_BUSY, 1,      "neg_busy_decay");
        checkOutput(t+4, SIG_OUT,  -32768, "neg_out4");
        checkOutput(t+4, SIG_BUSY, 0,      "neg_busy_idle");
        applyStimulus(1'b1, 1'b1);
        waitDrain();

        // Reset at the peak (with a competing trig), then a clean restart.
        baseline = 16'sd0;
        amp      = 16'd1000;
        t = edgeCnt + 1;
        checkOutput(t,    SIG_ACK,  1,    "rst_ack");
        checkOutput(t+1,  SIG_OUT,  250,  "rst_rise1");
        checkOutput(t+2,  SIG_OUT,  500,  "rst_rise2");
        checkOutput(t+3,  SIG_OUT,  750,  "rst_rise3");
        checkOutput(t+4,  SIG_OUT,  0,    "rst_peak_out");
        checkOutput(t+4,  SIG_ACK,  0,    "rst_peak_ack");
        checkOutput(t+4,  SIG_BUSY, 0,    "rst_peak_busy");
        checkOutput(t+5,  SIG_OUT,  0,    "rst_after_out");
        checkOutput(t+5,  SIG_BUSY, 0,    "rst_after_busy");
        checkOutput(t+6,  SIG_ACK,  1,    "resume_ack");
        checkOutput(t+7,  SIG_OUT,  250,  "resume_rise1");
        checkOutput(t+8,  SIG_OUT,  500,  "resume_rise2");
        checkOutput(t+9,  SIG_OUT,  750,  "resume_rise3");
        checkOutput(t+10, SIG_OUT,  1000, "resume_peak");
        checkOutput(t+11, SIG_OUT,  969,  "resume_decay");
        checkOutput(t+12, SIG_OUT,  0,    "final_reset_out");
        checkOutput(t+12, SIG_BUSY, 0,    "final_reset_busy");
        applyStimulus(1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDrain();

        // Auto trigger: period 100, coincident trig at the first tick, a
        // tick swallowed by a rise, then period 0 silences it.
        amp      = 16'd0;
        baseline = 16'sd0;
        t = edgeCnt;
        for (int k = 1; k <= 450; k++) begin
            checkOutput(t + k, SIG_ACK,
                        (k == 100 || k == 198 || k == 300) ? 1 : 0, "auto_ack");
        end
        for (int k = 1; k <= 450; k++) begin
            autoEn = 1'b1;
            period = (k >= 311) ? 16'd0 : 16'd100;
            applyStimulus(1'b1, (k == 100 || k == 198));
        end
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
